// File: rtl/game_pkg.sv
// Shared geometry, packed-position helpers and bullet state encoding for the
// enemy bullet controller and its motion step.
package game_pkg;

    localparam int POS_W    = 19;
    localparam int X_W      = 10;
    localparam int Y_W      = 9;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Off-screen parking spot so the collision checker never sees an idle bullet
    localparam logic [POS_W-1:0] PARK_POS = {10'd1023, 9'd511};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        HIT  = 2'd2
    } bulletState_t;

    function automatic logic [X_W-1:0] getX(input logic [POS_W-1:0] pos);
        return pos[POS_W-1 -: X_W];
    endfunction

    function automatic logic [Y_W-1:0] getY(input logic [POS_W-1:0] pos);
        return pos[Y_W-1:0];
    endfunction

endpackage

// File: rtl/bullet_step.sv
// Combinational per-tick motion: advances y by SPEED, flags bottom exit, and
// (with AIMED_SHOT_EN defined) steers x toward the player by up to AIM_STEP.
module bullet_step
    import game_pkg::*;
#(
    parameter int SPEED    = 4,
    parameter int SCREEN_H = game_pkg::SCREEN_H,
    parameter int AIM_STEP = 2
) (
    input  logic [POS_W-1:0] curPos,
    input  logic [X_W-1:0]   playerX,
    input  logic             tick,
    output logic [POS_W-1:0] nextPos,
    output logic             offScreen
);

    localparam logic [9:0] SPEED_L = 10'(SPEED);
    localparam logic [9:0] BOTTOM  = 10'(SCREEN_H);

    logic [X_W-1:0] curX;
    logic [X_W-1:0] aimX;
    logic [9:0]     yNext;

    assign curX  = getX(curPos);
    assign yNext = {1'b0, getY(curPos)} + SPEED_L;

`ifdef AIMED_SHOT_EN
    localparam logic [X_W-1:0] STEP_L = X_W'(AIM_STEP);
    localparam logic [X_W-1:0] X_MAX  = X_W'(SCREEN_W - 1);

    logic [X_W-1:0] stepX;

    // Snap to the player when within one step so x never overshoots
    always_comb begin
        stepX = curX;
        if (playerX > curX) begin
            stepX = ((playerX - curX) <= STEP_L) ? playerX : curX + STEP_L;
        end else if (playerX < curX) begin
            stepX = ((curX - playerX) <= STEP_L) ? playerX : curX - STEP_L;
        end
        aimX = (stepX > X_MAX) ? X_MAX : stepX;
    end
`else
    logic unusedPlayerX;
    assign unusedPlayerX = ^playerX;
    assign aimX          = curX;
`endif

    assign offScreen = tick && (yNext >= BOTTOM);
    assign nextPos   = tick ? {aimX, yNext[Y_W-1:0]} : curPos;

endmodule

// File: rtl/enemy_bullet_ctrl.sv
// Single enemy bullet lifecycle: spawn below the enemy, fall per frame, retire
// on player hit or bottom exit. Optional macro AIMED_SHOT_EN enables x homing.
//
// state | meaning
// IDLE  | parked off-screen, accepting fire requests
// FLY   | bullet in flight, moves on each frame tick
// HIT   | one-cycle hit pulse after a collision, then IDLE
module enemy_bullet_ctrl
    import game_pkg::*;
#(
    parameter int SPEED    = 4,
    parameter int SPAWN_DY = 16,
    parameter int SCREEN_H = game_pkg::SCREEN_H,
    parameter int AIM_STEP = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             i_FrameTick,
    input  logic             i_Fire,
    input  logic [POS_W-1:0] i_EnemyPos,
    input  logic [POS_W-1:0] i_PlayerPos,
    input  logic             i_IsCollision,
    output logic [POS_W-1:0] o_EnemyBulletPosition,
    output logic             o_BulletActive,
    output logic             o_FireAck,
    output logic             o_BulletHit
);

    localparam logic [9:0] SPAWN_L = 10'(SPAWN_DY);
    localparam logic [9:0] BOTTOM  = 10'(SCREEN_H);

    bulletState_t     state, stateNext;
    logic [POS_W-1:0] posReg, posNext, stepPos;
    logic             activeReg, activeNext;
    logic             ackReg, ackNext;
    logic             hitReg, hitNext;
    logic             stepOff;
    logic [9:0]       spawnY;
    logic             unusedPlayerY;

    assign spawnY        = {1'b0, getY(i_EnemyPos)} + SPAWN_L;
    assign unusedPlayerY = ^getY(i_PlayerPos);

    bullet_step #(
        .SPEED    (SPEED),
        .SCREEN_H (SCREEN_H),
        .AIM_STEP (AIM_STEP)
    ) uStep (
        .curPos    (posReg),
        .playerX   (getX(i_PlayerPos)),
        .tick      (i_FrameTick),
        .nextPos   (stepPos),
        .offScreen (stepOff)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= IDLE;
            posReg    <= PARK_POS;
            activeReg <= 1'b0;
            ackReg    <= 1'b0;
            hitReg    <= 1'b0;
        end else begin
            state     <= stateNext;
            posReg    <= posNext;
            activeReg <= activeNext;
            ackReg    <= ackNext;
            hitReg    <= hitNext;
        end
    end

    always_comb begin
        stateNext  = state;
        posNext    = posReg;
        activeNext = activeReg;
        ackNext    = 1'b0;
        hitNext    = 1'b0;
        unique case (state)
            IDLE: begin
                posNext    = PARK_POS;
                activeNext = 1'b0;
                if (i_Fire && (spawnY < BOTTOM)) begin
                    posNext    = {getX(i_EnemyPos), spawnY[Y_W-1:0]};
                    activeNext = 1'b1;
                    ackNext    = 1'b1;
                    stateNext  = FLY;
                end
            end
            FLY: begin
                // Collision wins over a same-cycle tick: the bullet does not move
                if (i_IsCollision) begin
                    stateNext  = HIT;
                    posNext    = PARK_POS;
                    activeNext = 1'b0;
                    hitNext    = 1'b1;
                end else if (i_FrameTick) begin
                    if (stepOff) begin
                        stateNext  = IDLE;
                        posNext    = PARK_POS;
                        activeNext = 1'b0;
                    end else begin
                        posNext = stepPos;
                    end
                end
            end
            HIT: begin
                stateNext  = IDLE;
                posNext    = PARK_POS;
                activeNext = 1'b0;
            end
            default: begin
                stateNext  = IDLE;
                posNext    = PARK_POS;
                activeNext = 1'b0;
            end
        endcase
    end

    assign o_EnemyBulletPosition = posReg;
    assign o_BulletActive        = activeReg;
    assign o_FireAck             = ackReg;
    assign o_BulletHit           = hitReg;

endmodule

// File: tb/tb_enemy_bullet_ctrl.sv
// Bench for enemy_bullet_ctrl: directed vector table, hand-written corner
// sequences and a randomized run against a behavioural bullet model.
module tb_enemy_bullet_ctrl;

    localparam logic [18:0] PARK = {10'd1023, 9'd511};

    logic        Clk = 1'b0;
    logic        Rst;
    logic        i_FrameTick, i_Fire, i_IsCollision;
    logic [18:0] i_EnemyPos, i_PlayerPos;
    logic [18:0] o_EnemyBulletPosition;
    logic        o_BulletActive, o_FireAck, o_BulletHit;

    int errors = 0;
    int checks = 0;

    enemy_bullet_ctrl dut (
        .Clk                   (Clk),
        .Rst                   (Rst),
        .i_FrameTick           (i_FrameTick),
        .i_Fire                (i_Fire),
        .i_EnemyPos            (i_EnemyPos),
        .i_PlayerPos           (i_PlayerPos),
        .i_IsCollision         (i_IsCollision),
        .o_EnemyBulletPosition (o_EnemyBulletPosition),
        .o_BulletActive        (o_BulletActive),
        .o_FireAck             (o_FireAck),
        .o_BulletHit           (o_BulletHit)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        fire, tick, coll;
        int          ex, ey, px;
        logic [18:0] expPos;
        logic        expAct, expAck, expHit;
    } vec_t;

    vec_t vecs[14];

    // behavioural model state
    bit mAlive, mHitCyc, mAck, mHit;
    int mX, mY;

    function automatic vec_t mk(input logic f, input logic t, input logic c,
                                input int ex, input int ey, input int px,
                                input logic [18:0] p, input logic a,
                                input logic k, input logic h);
        vec_t v;
        v.fire = f; v.tick = t; v.coll = c;
        v.ex = ex; v.ey = ey; v.px = px;
        v.expPos = p; v.expAct = a; v.expAck = k; v.expHit = h;
        return v;
    endfunction

    function automatic logic [18:0] pk(input int x, input int y);
        return {10'(x), 9'(y)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chkOut(input string nm, input logic [18:0] p, input logic a,
                          input logic k, input logic h);
        chk({nm, ".pos"}, 32'(o_EnemyBulletPosition), 32'(p));
        chk({nm, ".act"}, 32'(o_BulletActive), 32'(a));
        chk({nm, ".ack"}, 32'(o_FireAck), 32'(k));
        chk({nm, ".hit"}, 32'(o_BulletHit), 32'(h));
    endtask

    task automatic drive(input logic f, input logic t, input logic c,
                         input int ex, input int ey, input int px);
        i_Fire = f; i_FrameTick = t; i_IsCollision = c;
        i_EnemyPos  = pk(ex, ey);
        i_PlayerPos = pk(px, 0);
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    function automatic int aim(input int x, input int px);
`ifdef AIMED_SHOT_EN
        int d;
        d = px - x;
        if (d <= 2 && d >= -2) x = px;
        else if (d > 0) x = x + 2;
        else x = x - 2;
        if (x > 639) x = 639;
        if (x < 0) x = 0;
        return x;
`else
        if (px < 0) return x;
        return x;
`endif
    endfunction

    task automatic modelStep(input logic f, input logic t, input logic c,
                             input int ex, input int ey, input int px);
        mAck = 0;
        mHit = 0;
        if (mHitCyc) begin
            mHitCyc = 0;
        end else if (!mAlive) begin
            if (f && (ey + 16 < 480)) begin
                mAlive = 1; mX = ex; mY = ey + 16; mAck = 1;
            end
        end else if (c) begin
            mAlive = 0; mHitCyc = 1; mHit = 1;
        end else if (t) begin
            if (mY + 4 >= 480) mAlive = 0;
            else begin
                mY = mY + 4;
                mX = aim(mX, px);
            end
        end
    endtask

    task automatic fireAt(input int ex, input int ey, input int px);
        drive(1, 0, 0, ex, ey, px); cyc();
        drive(0, 0, 0, ex, ey, px);
    endtask

    task automatic retire();
        drive(0, 0, 1, 0, 0, 0); cyc();
        drive(0, 0, 0, 0, 0, 0); cyc();
    endtask

    initial begin
        int expX;
        vecs[0]  = mk(1, 0, 0, 100,  50, 100, pk(100, 66), 1, 1, 0);
        vecs[1]  = mk(0, 0, 0, 100,  50, 100, pk(100, 66), 1, 0, 0);
        vecs[2]  = mk(0, 1, 0, 100,  50, 100, pk(100, 70), 1, 0, 0);
        vecs[3]  = mk(0, 1, 0, 100,  50, 100, pk(100, 74), 1, 0, 0);
        vecs[4]  = mk(0, 1, 0, 100,  50, 100, pk(100, 78), 1, 0, 0);
        vecs[5]  = mk(1, 0, 0, 300, 200, 100, pk(100, 78), 1, 0, 0);
        vecs[6]  = mk(0, 1, 1, 300, 200, 100, PARK,        0, 0, 1);
        vecs[7]  = mk(1, 0, 0, 300, 456, 300, PARK,        0, 0, 0);
        vecs[8]  = mk(1, 0, 0, 300, 456, 300, pk(300, 472), 1, 1, 0);
        vecs[9]  = mk(0, 1, 0, 300, 456, 300, pk(300, 476), 1, 0, 0);
        vecs[10] = mk(0, 1, 0, 300, 456, 300, PARK,        0, 0, 0);
        vecs[11] = mk(1, 0, 0, 300, 470, 300, PARK,        0, 0, 0);
        vecs[12] = mk(1, 0, 0,   5, 463,   5, pk(5, 479),  1, 1, 0);
        vecs[13] = mk(0, 1, 0,   5, 463,   5, PARK,        0, 0, 0);

        Rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #100;
        chkOut("reset", PARK, 0, 0, 0);
        @(negedge Clk);
        Rst = 1'b1;
        repeat (3) cyc();
        chkOut("post_reset_idle", PARK, 0, 0, 0);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].fire, vecs[i].tick, vecs[i].coll,
                  vecs[i].ex, vecs[i].ey, vecs[i].px);
            cyc();
            chkOut($sformatf("vec%0d", i), vecs[i].expPos, vecs[i].expAct,
                   vecs[i].expAck, vecs[i].expHit);
        end
        drive(0, 0, 0, 0, 0, 0);
        cyc();

        // asynchronous reset in the middle of a flight
        fireAt(50, 100, 50);
        chk("midrst.pre_act", 32'(o_BulletActive), 32'd1);
        #2 Rst = 1'b0;
        #1;
        chkOut("midrst", PARK, 0, 0, 0);
        cyc();
        chkOut("midrst_hold", PARK, 0, 0, 0);
        @(negedge Clk);
        Rst = 1'b1;
        cyc();

        // x steering (or fixed x in the default build)
        fireAt(100, 50, 200);
        drive(0, 1, 0, 0, 0, 200); cyc();
`ifdef AIMED_SHOT_EN
        expX = 102;
`else
        expX = 100;
`endif
        chk("aim.x100", 32'(o_EnemyBulletPosition[18:9]), 32'(expX));
        chk("aim.y", 32'(o_EnemyBulletPosition[8:0]), 32'd70);
        retire();

        fireAt(199, 50, 200);
        drive(0, 1, 0, 0, 0, 200); cyc();
        chk("aim.x199a", 32'(o_EnemyBulletPosition[18:9]), 32'(aim(199, 200)));
`ifdef AIMED_SHOT_EN
        chk("aim.x199a_abs", 32'(o_EnemyBulletPosition[18:9]), 32'd200);
`endif
        cyc();
        chk("aim.x199b", 32'(o_EnemyBulletPosition[18:9]), 32'(aim(aim(199, 200), 200)));
        retire();

        fireAt(1, 50, 0);
        drive(0, 1, 0, 0, 0, 0); cyc();
        chk("aim.x1", 32'(o_EnemyBulletPosition[18:9]), 32'(aim(1, 0)));
        retire();

        // randomized run against the model
        Rst = 1'b0;
        #3;
        @(negedge Clk);
        Rst = 1'b1;
        mAlive = 0; mHitCyc = 0; mAck = 0; mHit = 0; mX = 0; mY = 0;
        for (int n = 0; n < 3000; n++) begin
            logic f, t, c;
            int ex, ey, px;
            f  = ($urandom_range(0, 3) == 0);
            t  = ($urandom_range(0, 2) == 0);
            c  = ($urandom_range(0, 39) == 0);
            ex = $urandom_range(0, 1023);
            ey = $urandom_range(0, 511);
            px = $urandom_range(0, 700);
            drive(f, t, c, ex, ey, px);
            cyc();
            modelStep(f, t, c, ex, ey, px);
            chkOut($sformatf("rnd%0d", n), mAlive ? pk(mX, mY) : PARK,
                   mAlive, mAck, mHit);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
